strobe_seq: RTL and testbench
=============================

# strobe_seq

Burst strobe sequencer that drives the select and enable inputs of the 3-to-8 active-low-enable decoder cell. On a start request it issues 1–8 consecutive decoder strobes beginning at a programmable index, wrapping 7→0. Each strobe is held for a programmable number of wait cycles. Busy and done status are reported to the bus-cycle controller. Outputs are registered, so the decoder sees glitch-free select and enable.

## Interface
- `WAIT_W`, default 3: width of the per-strobe wait-state count.
- `sys_clk`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  burst request; sampled only in IDLE.
- `first`  in  3  index of the first strobe.
- `count`  in  3  number of strobes minus 1 (0 → 1 strobe, 7 → 8 strobes).
- `wait_cyc`  in  WAIT_W  extra cycles each strobe is held (0 → 1 cycle).
- `hold`  in  1  stall; freezes all state, counters and outputs.
- `a`  out  3  decoder select (a[0] to a0, a[1] to a1, a[2] to a2).
- `gn`  out  1  decoder enable, active low.
- `busy`  out  1  high from the first strobe cycle through the last strobe cycle.
- `done`  out  1  one-cycle pulse in the cycle after the last strobe ends.

## Operation
- Reset values: `a`=0, `gn`=1, `busy`=0, `done`=0, state IDLE, all counters 0.
- IDLE: `gn`=1 and `a` holds its last value.
  - `start`=1 and `hold`=0 at an edge: latch `first` into `a`, `count` into the remaining-strobe counter and `wait_cyc` into the wait counter.
  - Go to STROBE.
- STROBE: `gn`=0, `busy`=1. Each edge with `hold`=0 decrements the wait counter. When the wait counter is 0:
  - If remaining = 0: go to IDLE with `gn`=1, `busy`=0, and `done`=1 for one cycle.
  - Otherwise: `a` <= `a`+1 mod 8, remaining decrements, the wait counter reloads from the latched `wait_cyc`, and the next state is given under Configuration.
- GAP (only with the macro defined): `gn`=1, `busy`=1, `a` already advanced. The next edge with `hold`=0 goes to STROBE.
- `first`, `count` and `wait_cyc` are latched at start; changes during a burst are ignored.
- `start` is ignored outside IDLE. `start` in the same cycle as `done` is accepted, because the state is IDLE.
- `hold`=1 in any state: no change at the edge; a pending `done` pulse is extended while `hold` stays high.
- `reset` mid-burst: at the next edge all reset values are restored, with no `done` pulse. `reset` takes priority over `start` and `hold`.

## Timing
- Start to first strobe: 1 cycle. `gn` falls in the cycle after `start` is sampled.
- Each strobe lasts `wait_cyc`+1 cycles when `hold`=0.
- Burst length without the macro: (`count`+1)·(`wait_cyc`+1) cycles of `gn`=0. `gn` stays low continuously across strobes; only `a` changes.
- Burst length with the macro: add `count` gap cycles.
- `done` is asserted in the cycle after the last `gn`=0 cycle.
- All outputs come directly from flops; there is no combinational path from any input to any output.

## Configuration
- `STROBE_SEQ_GAP_EN` defined: STROBE→GAP→STROBE between consecutive strobes. `gn` goes high for exactly one cycle while `a` changes, so decoder outputs never overlap.
- `STROBE_SEQ_GAP_EN` undefined: STROBE→STROBE back-to-back. The GAP state and its logic are not compiled.

## Structure
- Package `strobe_seq_pkg` contains:
  - the state enum (IDLE, STROBE, GAP);
  - the `SEL_W`=3 constant;
  - the default `WAIT_W` constant.
- One sub-module, `strobe_wait_cnt`: a loadable down-counter of width `WAIT_W` with load, enable (`!hold`) and zero-flag outputs. It is instantiated once for the wait count.
- The remaining-strobe counter and the select increment stay inline.

## Test plan
- `first`=2, `count`=0, `wait_cyc`=0, pulse `start` → one cycle of `a`=2, `gn`=0; next cycle `gn`=1, `done`=1.
- `first`=6, `count`=3, `wait_cyc`=1, no macro → `a` = 6,6,7,7,0,0,1,1 with `gn`=0 for 8 cycles; `done` asserted on cycle 9.
- Same stimulus with `STROBE_SEQ_GAP_EN` → 11 cycles total, with `gn`=1 single cycles after each of the first three strobes.
- `hold`=1 for 3 cycles mid-strobe → `a`, `gn` and `busy` frozen; total burst length extended by exactly 3 cycles.
- `reset` pulsed during the 2nd strobe of a `count`=4 burst → next cycle `a`=0, `gn`=1, `busy`=0; no `done` pulse.
- `start` held high continuously with `count`=1, `wait_cyc`=0 → new burst starts in the `done` cycle; `gn` is high only in that cycle between bursts.

Source files
------------

// File: rtl/strobe_seq_pkg.sv
// Shared types and constants for the burst strobe sequencer.
package strobe_seq_pkg;

    localparam int SEL_W      = 3;
    localparam int WAIT_W_DEF = 3;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STROBE = 2'd1,
        GAP    = 2'd2
    } state_e;

endpackage

// File: rtl/strobe_seq_if.sv
// Bus-cycle controller <-> strobe sequencer signal bundle.
interface strobe_seq_if #(
    parameter int WAIT_W = strobe_seq_pkg::WAIT_W_DEF
);
    import strobe_seq_pkg::*;

    logic              start;
    logic [SEL_W-1:0]  first;
    logic [SEL_W-1:0]  count;
    logic [WAIT_W-1:0] wait_cyc;
    logic              hold;
    logic [SEL_W-1:0]  a;
    logic              gn;
    logic              busy;
    logic              done;

    modport master (
        output start, first, count, wait_cyc, hold,
        input  a, gn, busy, done
    );

    modport slave (
        input  start, first, count, wait_cyc, hold,
        output a, gn, busy, done
    );

endinterface

// File: rtl/strobe_wait_cnt.sv
// Loadable down-counter for per-strobe wait states; load wins over enable,
// counting stops at zero and zero is flagged from the register.
module strobe_wait_cnt #(
    parameter int WAIT_W = strobe_seq_pkg::WAIT_W_DEF
) (
    input  logic              sys_clk,
    input  logic              reset,
    input  logic              load,
    input  logic [WAIT_W-1:0] load_val,
    input  logic              en,
    output logic              zero
);

    logic [WAIT_W-1:0] cnt_q;
    logic [WAIT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (en && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/strobe_seq.sv
// Burst strobe sequencer for a 3-to-8 decoder: 1-8 strobes from a start index,
// all outputs registered. STROBE_SEQ_GAP_EN inserts a one-cycle gn gap between strobes.
module strobe_seq
    import strobe_seq_pkg::*;
#(
    parameter int WAIT_W = WAIT_W_DEF
) (
    input  logic         sys_clk,
    input  logic         reset,
    strobe_seq_if.slave  bus
);

    localparam logic [1:0] S_IDLE   = IDLE;
    localparam logic [1:0] S_STROBE = STROBE;
`ifdef STROBE_SEQ_GAP_EN
    localparam logic [1:0] S_GAP    = GAP;
`endif

    logic [1:0]        state_q, state_d;
    logic [SEL_W-1:0]  a_q, a_d;
    logic              gn_q, gn_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [SEL_W-1:0]  rem_q, rem_d;
    logic [WAIT_W-1:0] wlat_q, wlat_d;

    logic              wc_load;
    logic [WAIT_W-1:0] wc_val;
    logic              wc_en;
    logic              wc_zero;

    strobe_wait_cnt #(.WAIT_W(WAIT_W)) u_wait_cnt (
        .sys_clk  (sys_clk),
        .reset    (reset),
        .load     (wc_load),
        .load_val (wc_val),
        .en       (wc_en),
        .zero     (wc_zero)
    );

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        gn_d    = gn_q;
        busy_d  = busy_q;
        done_d  = done_q;
        rem_d   = rem_q;
        wlat_d  = wlat_q;
        wc_load = 1'b0;
        wc_val  = wlat_q;
        wc_en   = 1'b0;

        // hold freezes everything, including a pending done pulse
        if (!bus.hold) begin
            done_d = 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (bus.start) begin
                        a_d     = bus.first;
                        rem_d   = bus.count;
                        wlat_d  = bus.wait_cyc;
                        wc_load = 1'b1;
                        wc_val  = bus.wait_cyc;
                        gn_d    = 1'b0;
                        busy_d  = 1'b1;
                        state_d = S_STROBE;
                    end
                end
                S_STROBE: begin
                    if (!wc_zero) begin
                        wc_en = 1'b1;
                    end else if (rem_q == '0) begin
                        gn_d    = 1'b1;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        a_d     = a_q + 1'b1;
                        rem_d   = rem_q - 1'b1;
                        wc_load = 1'b1;
`ifdef STROBE_SEQ_GAP_EN
                        gn_d    = 1'b1;
                        state_d = S_GAP;
`endif
                    end
                end
`ifdef STROBE_SEQ_GAP_EN
                S_GAP: begin
                    gn_d    = 1'b0;
                    state_d = S_STROBE;
                end
`endif
                default: begin
                    gn_d    = 1'b1;
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge sys_clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            gn_q    <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            rem_q   <= '0;
            wlat_q  <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            gn_q    <= gn_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            rem_q   <= rem_d;
            wlat_q  <= wlat_d;
        end
    end

    assign bus.a    = a_q;
    assign bus.gn   = gn_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;

endmodule

// File: tb/tb_strobe_seq.sv
// Self-checking bench for strobe_seq: vector table, directed bursts, random vs. burst-queue model.
module tb_strobe_seq;
    import strobe_seq_pkg::*;

    localparam int WW = WAIT_W_DEF;

    typedef struct packed {
        logic [2:0] a;
        logic       gn;
        logic       busy;
        logic       done;
    } out_t;

    typedef struct {
        logic          st;
        logic [2:0]    f;
        logic [2:0]    c;
        logic [WW-1:0] w;
        logic          h;
        logic          r;
        out_t          exp;
    } vec_t;

    logic sys_clk = 1'b0;
    logic reset;
    always #5 sys_clk = ~sys_clk;

    strobe_seq_if #(.WAIT_W(WW)) bus();

    strobe_seq #(.WAIT_W(WW)) dut (
        .sys_clk (sys_clk),
        .reset   (reset),
        .bus     (bus)
    );

    int   vectors     = 0;
    int   miscompares = 0;
    out_t q[$];
    out_t exp_o;

    // Expand a burst into its cycle-by-cycle output trace from the timing rules.
    task automatic build_burst(input logic [2:0] f, input logic [2:0] c, input logic [WW-1:0] w);
        for (int k = 0; k <= int'(c); k++) begin
            for (int i = 0; i <= int'(w); i++)
                q.push_back(out_t'{3'(int'(f) + k), 1'b0, 1'b1, 1'b0});
`ifdef STROBE_SEQ_GAP_EN
            if (k < int'(c))
                q.push_back(out_t'{3'(int'(f) + k + 1), 1'b1, 1'b1, 1'b0});
`endif
        end
        q.push_back(out_t'{3'(int'(f) + int'(c)), 1'b1, 1'b0, 1'b1});
    endtask

    task automatic model_edge(input logic st, input logic [2:0] f, input logic [2:0] c,
                              input logic [WW-1:0] w, input logic h, input logic r);
        if (r) begin
            exp_o = out_t'{3'd0, 1'b1, 1'b0, 1'b0};
            q.delete();
        end else if (!h) begin
            if (q.size() == 0) begin
                if (st) build_burst(f, c, w);
                else begin
                    exp_o.gn   = 1'b1;
                    exp_o.busy = 1'b0;
                    exp_o.done = 1'b0;
                end
            end
            if (q.size() != 0) exp_o = q.pop_front();
        end
    endtask

    task automatic check(input string nm, input out_t e);
        out_t got;
        got = {bus.a, bus.gn, bus.busy, bus.done};
        vectors++;
        if (got !== e) begin
            miscompares++;
            $display("FAIL %s: got a=%0d gn=%b busy=%b done=%b, expected a=%0d gn=%b busy=%b done=%b",
                     nm, got.a, got.gn, got.busy, got.done, e.a, e.gn, e.busy, e.done);
        end
    endtask

    // Drive one cycle of inputs, advance the model, compare after the edge.
    // use_exp selects a hand-written expectation instead of the model's.
    task automatic step(input logic st, input logic [2:0] f, input logic [2:0] c,
                        input logic [WW-1:0] w, input logic h, input logic r,
                        input string nm, input logic use_exp, input out_t e);
        @(negedge sys_clk);
        bus.start = st; bus.first = f; bus.count = c; bus.wait_cyc = w;
        bus.hold = h; reset = r;
        model_edge(st, f, c, w, h, r);
        @(posedge sys_clk);
        #1;
        check(nm, use_exp ? e : exp_o);
    endtask

    task automatic mstep(input logic st, input logic [2:0] f, input logic [2:0] c,
                         input logic [WW-1:0] w, input logic h, input logic r, input string nm);
        step(st, f, c, w, h, r, nm, 1'b0, '0);
    endtask

    vec_t tbl[17];

`ifdef STROBE_SEQ_GAP_EN
    localparam int SEQ_N = 12;
    out_t seq_exp [SEQ_N] = '{
        {3'd6,3'b010}, {3'd6,3'b010}, {3'd7,3'b110}, {3'd7,3'b010}, {3'd7,3'b010},
        {3'd0,3'b110}, {3'd0,3'b010}, {3'd0,3'b010}, {3'd1,3'b110}, {3'd1,3'b010},
        {3'd1,3'b010}, {3'd1,3'b101}};
`else
    localparam int SEQ_N = 9;
    out_t seq_exp [SEQ_N] = '{
        {3'd6,3'b010}, {3'd6,3'b010}, {3'd7,3'b010}, {3'd7,3'b010},
        {3'd0,3'b010}, {3'd0,3'b010}, {3'd1,3'b010}, {3'd1,3'b010}, {3'd1,3'b101}};
`endif

    initial begin
        reset = 1'b1;
        bus.start = 1'b0; bus.first = '0; bus.count = '0; bus.wait_cyc = '0; bus.hold = 1'b0;
        exp_o = out_t'{3'd0, 1'b1, 1'b0, 1'b0};

        //           st    f     c     w     h     r      a    gn busy done
        tbl[0]  = '{1'b0, 3'd0, 3'd0, 3'd0, 1'b0, 1'b1, '{3'd0, 1'b1, 1'b0, 1'b0}};
        tbl[1]  = '{1'b1, 3'd2, 3'd0, 3'd0, 1'b0, 1'b0, '{3'd2, 1'b0, 1'b1, 1'b0}};
        tbl[2]  = '{1'b0, 3'd0, 3'd0, 3'd0, 1'b0, 1'b0, '{3'd2, 1'b1, 1'b0, 1'b1}};
        tbl[3]  = '{1'b0, 3'd0, 3'd0, 3'd0, 1'b0, 1'b0, '{3'd2, 1'b1, 1'b0, 1'b0}};
        tbl[4]  = '{1'b1, 3'd5, 3'd0, 3'd2, 1'b0, 1'b0, '{3'd5, 1'b0, 1'b1, 1'b0}};
        tbl[5]  = '{1'b1, 3'd1, 3'd7, 3'd0, 1'b0, 1'b0, '{3'd5, 1'b0, 1'b1, 1'b0}};
        tbl[6]  = '{1'b0, 3'd0, 3'd0, 3'd0, 1'b0, 1'b0, '{3'd5, 1'b0, 1'b1, 1'b0}};
        tbl[7]  = '{1'b0, 3'd0, 3'd0, 3'd0, 1'b0, 1'b0, '{3'd5, 1'b1, 1'b0, 1'b1}};
        tbl[8]  = '{1'b0, 3'd0, 3'd0, 3'd0, 1'b1, 1'b0, '{3'd5, 1'b1, 1'b0, 1'b1}};
        tbl[9]  = '{1'b1, 3'd3, 3'd0, 3'd0, 1'b1, 1'b0, '{3'd5, 1'b1, 1'b0, 1'b1}};
        tbl[10] = '{1'b0, 3'd0, 3'd0, 3'd0, 1'b0, 1'b0, '{3'd5, 1'b1, 1'b0, 1'b0}};
        tbl[11] = '{1'b1, 3'd7, 3'd0, 3'd0, 1'b1, 1'b0, '{3'd5, 1'b1, 1'b0, 1'b0}};
        tbl[12] = '{1'b1, 3'd7, 3'd0, 3'd0, 1'b0, 1'b0, '{3'd7, 1'b0, 1'b1, 1'b0}};
        tbl[13] = '{1'b1, 3'd3, 3'd0, 3'd0, 1'b0, 1'b0, '{3'd7, 1'b1, 1'b0, 1'b1}};
        tbl[14] = '{1'b1, 3'd3, 3'd0, 3'd0, 1'b0, 1'b0, '{3'd3, 1'b0, 1'b1, 1'b0}};
        tbl[15] = '{1'b0, 3'd0, 3'd0, 3'd0, 1'b0, 1'b1, '{3'd0, 1'b1, 1'b0, 1'b0}};
        tbl[16] = '{1'b0, 3'd0, 3'd0, 3'd0, 1'b0, 1'b0, '{3'd0, 1'b1, 1'b0, 1'b0}};

        for (int i = 0; i < 17; i++)
            step(tbl[i].st, tbl[i].f, tbl[i].c, tbl[i].w, tbl[i].h, tbl[i].r,
                 $sformatf("tbl%0d", i), 1'b1, tbl[i].exp);

        // first=6 count=3 wait=1: wrapping select, gap pattern depends on the build
        step(1'b1, 3'd6, 3'd3, 3'd1, 1'b0, 1'b0, "burst6_0", 1'b1, seq_exp[0]);
        for (int i = 1; i < SEQ_N; i++)
            step(1'b0, 3'd0, 3'd0, 3'd0, 1'b0, 1'b0, $sformatf("burst6_%0d", i), 1'b1, seq_exp[i]);
        step(1'b0, 3'd0, 3'd0, 3'd0, 1'b0, 1'b0, "burst6_idle", 1'b1, '{3'd1, 1'b1, 1'b0, 1'b0});

        // hold for 3 cycles mid-strobe
        mstep(1'b1, 3'd1, 3'd2, 3'd1, 1'b0, 1'b0, "hold_start");
        mstep(1'b0, 3'd0, 3'd0, 3'd0, 1'b0, 1'b0, "hold_pre");
        for (int i = 0; i < 3; i++) mstep(1'b0, 3'd0, 3'd0, 3'd0, 1'b1, 1'b0, "hold_frz");
        for (int i = 0; i < 10; i++) mstep(1'b0, 3'd0, 3'd0, 3'd0, 1'b0, 1'b0, "hold_run");

        // reset during the 2nd strobe of a count=4 burst
        mstep(1'b1, 3'd4, 3'd4, 3'd1, 1'b0, 1'b0, "rst_start");
        for (int i = 0; i < 2; i++) mstep(1'b0, 3'd0, 3'd0, 3'd0, 1'b0, 1'b0, "rst_run");
        mstep(1'b1, 3'd5, 3'd2, 3'd0, 1'b1, 1'b1, "rst_hit");
        for (int i = 0; i < 3; i++) mstep(1'b0, 3'd0, 3'd0, 3'd0, 1'b0, 1'b0, "rst_after");

        // start held continuously: restart in each done cycle
        for (int i = 0; i < 12; i++) mstep(1'b1, 3'd7, 3'd1, 3'd0, 1'b0, 1'b0, "start_held");
        for (int i = 0; i < 4; i++) mstep(1'b0, 3'd0, 3'd0, 3'd0, 1'b0, 1'b0, "start_drain");

        for (int i = 0; i < 800; i++) begin
            mstep(($urandom_range(0, 99) < 35) ? 1'b1 : 1'b0,
                  3'($urandom), 3'($urandom), WW'($urandom),
                  ($urandom_range(0, 99) < 15) ? 1'b1 : 1'b0,
                  ($urandom_range(0, 99) < 2) ? 1'b1 : 1'b0,
                  "random");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
